// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the two initiators (CPU controller, DMA copy engine),
// the single-port SRAM and the arbiter that sits between them.
// The slave modport is the arbiter's view; the master modport is the view of
// everything around it (both initiators plus the SRAM macro).
interface sram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    // CPU initiator
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    // DMA initiator
    logic              dma_req;
    logic              dma_we;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_starved;

    // SRAM port
    logic              mem_EN;
    logic              mem_WE;
    logic [ADDR_W-1:0] mem_ADDR;
    logic [DATA_W-1:0] mem_DI;
    logic [DATA_W-1:0] mem_DO;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata, dma_starved,
        output mem_EN, mem_WE, mem_ADDR, mem_DI,
        input  mem_DO
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata, dma_starved,
        input  mem_EN, mem_WE, mem_ADDR, mem_DI,
        output mem_DO
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Two-initiator arbiter in front of a single-port SRAM.
// The CPU normally wins ties; a starvation counter hands priority to the DMA
// once it has been denied STARVE_LIMIT consecutive cycles, so copies always
// progress. Grants are combinational, read data returns one cycle after the
// grant on the owning initiator's rvalid/rdata, with the other side held at 0.
// While reset is held no access is issued and no read data is presented.
module sram_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    sram_port_arbiter_if.slave bus
);

    typedef enum logic {
        CPU_PRIO = 1'b0,
        DMA_PRIO = 1'b1
    } prioState_t;

    // Counter value on which one more denied DMA cycle flips priority.
    localparam logic [3:0] STARVE_LAST = 4'(STARVE_LIMIT - 1);

    prioState_t        state_q;
    logic              starved_q;
    logic [3:0]        starveCnt_q, starveCnt_d;
    logic              rdPend_q, rdPend_d;
    logic              rdOwnerDma_q, rdOwnerDma_d;

    logic              cpuWins;
    logic              cpuGnt;
    logic              dmaGnt;
    logic              dmaDenied;
    logic              starveHit;

    logic              memEn;
    logic              memWe;
    logic [ADDR_W-1:0] winAddr;
    logic [DATA_W-1:0] winData;

    logic              cpuRvalid;
    logic              dmaRvalid;

    // Pick the winner from the live requests and the current priority state.
    always_comb begin
        cpuWins = bus.cpu_req && (!bus.dma_req || (state_q == CPU_PRIO));
        cpuGnt  = !reset && cpuWins;
        dmaGnt  = !reset && bus.dma_req && !cpuWins;
    end

    // A denied DMA request this cycle, and whether it is the one that starves it.
    always_comb begin
        dmaDenied = bus.dma_req && !dmaGnt;
        starveHit = dmaDenied && (starveCnt_q == STARVE_LAST);
    end

    // Count consecutive denied DMA cycles, saturating at the top of the range.
    always_comb begin
        starveCnt_d = '0;
        if (dmaDenied) begin
            starveCnt_d = (starveCnt_q == 4'hF) ? starveCnt_q : starveCnt_q + 4'd1;
        end
    end

    // Steer the winner's controls onto the SRAM port; reads never drive write data.
    always_comb begin
        memEn   = 1'b0;
        memWe   = 1'b0;
        winAddr = '0;
        winData = '0;
        if (cpuGnt) begin
            memEn   = 1'b1;
            memWe   = bus.cpu_we;
            winAddr = bus.cpu_addr;
            winData = bus.cpu_we ? bus.cpu_wdata : '0;
        end else if (dmaGnt) begin
            memEn   = 1'b1;
            memWe   = bus.dma_we;
            winAddr = bus.dma_addr;
            winData = bus.dma_we ? bus.dma_wdata : '0;
        end
    end

    // Remember whether this cycle issues a read and who owns the returning data.
    always_comb begin
        rdPend_d     = memEn && !memWe;
        rdOwnerDma_d = dmaGnt;
    end

    // Priority FSM with the starved flag registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= CPU_PRIO;
            starved_q <= 1'b0;
        end else begin
            case (state_q)
                CPU_PRIO: begin
                    if (starveHit) begin
                        state_q   <= DMA_PRIO;
                        starved_q <= 1'b1;
                    end
                end
                DMA_PRIO: begin
                    if (dmaGnt || !bus.dma_req) begin
                        state_q   <= CPU_PRIO;
                        starved_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= CPU_PRIO;
                    starved_q <= 1'b0;
                end
            endcase
        end
    end

    // Starvation counter and pending-read tag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt_q  <= '0;
            rdPend_q     <= 1'b0;
            rdOwnerDma_q <= 1'b0;
        end else begin
            starveCnt_q  <= starveCnt_d;
            rdPend_q     <= rdPend_d;
            rdOwnerDma_q <= rdOwnerDma_d;
        end
    end

    // Route the returning SRAM word only to the initiator that issued the read.
    always_comb begin
        cpuRvalid = !reset && rdPend_q && !rdOwnerDma_q;
        dmaRvalid = !reset && rdPend_q && rdOwnerDma_q;
    end

    assign bus.cpu_gnt     = cpuGnt;
    assign bus.dma_gnt     = dmaGnt;
    assign bus.dma_starved = starved_q && !reset;

    assign bus.mem_EN      = memEn;
    assign bus.mem_WE      = memWe;
    assign bus.mem_ADDR    = winAddr;
    assign bus.mem_DI      = winData;

    assign bus.cpu_rvalid  = cpuRvalid;
    assign bus.cpu_rdata   = cpuRvalid ? bus.mem_DO : '0;
    assign bus.dma_rvalid  = dmaRvalid;
    assign bus.dma_rdata   = dmaRvalid ? bus.mem_DO : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: a directed vector table, a few multi-cycle
// corner-case sequences, then randomized traffic checked against a
// cycle-level reference model of the arbitration rules and a shadow memory.
module tb_sram_port_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    typedef struct packed {
        logic              cpuReq;
        logic              cpuWe;
        logic [ADDR_W-1:0] cpuAddr;
        logic [DATA_W-1:0] cpuWdata;
        logic              dmaReq;
        logic              dmaWe;
        logic [ADDR_W-1:0] dmaAddr;
        logic [DATA_W-1:0] dmaWdata;
    } inVec_t;

    typedef struct packed {
        logic              cpuGnt;
        logic              dmaGnt;
        logic              memEn;
        logic              memWe;
        logic [ADDR_W-1:0] memAddr;
        logic [DATA_W-1:0] memDi;
        logic              cpuRvalid;
        logic [DATA_W-1:0] cpuRdata;
        logic              dmaRvalid;
        logic [DATA_W-1:0] dmaRdata;
        logic              starved;
    } outVec_t;

    typedef struct {
        inVec_t  stim;
        outVec_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;

    int assertCount = 0;
    int failCount   = 0;

    sram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Write-first SRAM macro model driving mem_DO the cycle after an access.
    bit [DATA_W-1:0] sramArr [0:65535];
    always @(posedge clk) begin
        if (bus.mem_EN) begin
            if (bus.mem_WE) begin
                sramArr[bus.mem_ADDR] <= bus.mem_DI;
                bus.mem_DO            <= bus.mem_DI;
            end else begin
                bus.mem_DO <= sramArr[bus.mem_ADDR];
            end
        end
    end

    // Reference model state: how long the DMA has waited, what read is in flight.
    bit [DATA_W-1:0] shadowArr [0:65535];
    int              mdlWait;
    bit              mdlPend;
    bit              mdlPendDma;
    bit [DATA_W-1:0] mdlPendData;
    outVec_t         eOut;

    function automatic inVec_t mkIn(logic cq, logic cw, logic [ADDR_W-1:0] ca, logic [DATA_W-1:0] cd,
                                    logic dq, logic dw, logic [ADDR_W-1:0] da, logic [DATA_W-1:0] dd);
        inVec_t v;
        v.cpuReq = cq; v.cpuWe = cw; v.cpuAddr = ca; v.cpuWdata = cd;
        v.dmaReq = dq; v.dmaWe = dw; v.dmaAddr = da; v.dmaWdata = dd;
        return v;
    endfunction

    function automatic outVec_t mkOut(logic cg, logic dg, logic en, logic we, logic [ADDR_W-1:0] a,
                                      logic [DATA_W-1:0] di, logic cv, logic [DATA_W-1:0] cd,
                                      logic dv, logic [DATA_W-1:0] dd, logic st);
        outVec_t v;
        v.cpuGnt = cg; v.dmaGnt = dg; v.memEn = en; v.memWe = we; v.memAddr = a; v.memDi = di;
        v.cpuRvalid = cv; v.cpuRdata = cd; v.dmaRvalid = dv; v.dmaRdata = dd; v.starved = st;
        return v;
    endfunction

    task automatic applyStimulus(input inVec_t v);
        bus.cpu_req   = v.cpuReq;
        bus.cpu_we    = v.cpuWe;
        bus.cpu_addr  = v.cpuAddr;
        bus.cpu_wdata = v.cpuWdata;
        bus.dma_req   = v.dmaReq;
        bus.dma_we    = v.dmaWe;
        bus.dma_addr  = v.dmaAddr;
        bus.dma_wdata = v.dmaWdata;
    endtask

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag, input outVec_t exp);
        checkVal({tag, ".cpu_gnt"},     64'(bus.cpu_gnt),     64'(exp.cpuGnt));
        checkVal({tag, ".dma_gnt"},     64'(bus.dma_gnt),     64'(exp.dmaGnt));
        checkVal({tag, ".mem_EN"},      64'(bus.mem_EN),      64'(exp.memEn));
        checkVal({tag, ".mem_WE"},      64'(bus.mem_WE),      64'(exp.memWe));
        checkVal({tag, ".mem_ADDR"},    64'(bus.mem_ADDR),    64'(exp.memAddr));
        checkVal({tag, ".mem_DI"},      64'(bus.mem_DI),      64'(exp.memDi));
        checkVal({tag, ".cpu_rvalid"},  64'(bus.cpu_rvalid),  64'(exp.cpuRvalid));
        checkVal({tag, ".cpu_rdata"},   64'(bus.cpu_rdata),   64'(exp.cpuRdata));
        checkVal({tag, ".dma_rvalid"},  64'(bus.dma_rvalid),  64'(exp.dmaRvalid));
        checkVal({tag, ".dma_rdata"},   64'(bus.dma_rdata),   64'(exp.dmaRdata));
        checkVal({tag, ".dma_starved"}, 64'(bus.dma_starved), 64'(exp.starved));
    endtask

    // Expected outputs this cycle from the driven inputs and the model state.
    task automatic modelEval();
        bit dmaPrio;
        dmaPrio = (mdlWait >= STARVE_LIMIT);
        eOut = '0;
        if (!reset) begin
            if (bus.cpu_req && (!bus.dma_req || !dmaPrio)) begin
                eOut.cpuGnt  = 1'b1;
                eOut.memWe   = bus.cpu_we;
                eOut.memAddr = bus.cpu_addr;
                eOut.memDi   = bus.cpu_we ? bus.cpu_wdata : '0;
            end else if (bus.dma_req) begin
                eOut.dmaGnt  = 1'b1;
                eOut.memWe   = bus.dma_we;
                eOut.memAddr = bus.dma_addr;
                eOut.memDi   = bus.dma_we ? bus.dma_wdata : '0;
            end
            eOut.memEn = eOut.cpuGnt | eOut.dmaGnt;
            if (mdlPend && mdlPendDma) begin
                eOut.dmaRvalid = 1'b1;
                eOut.dmaRdata  = mdlPendData;
            end else if (mdlPend) begin
                eOut.cpuRvalid = 1'b1;
                eOut.cpuRdata  = mdlPendData;
            end
            eOut.starved = dmaPrio;
        end
    endtask

    // Advance the model across the clock edge.
    task automatic modelCommit();
        if (reset) begin
            mdlWait = 0;
            mdlPend = 1'b0;
        end else begin
            mdlPend    = eOut.memEn && !eOut.memWe;
            mdlPendDma = eOut.dmaGnt;
            if (mdlPend) mdlPendData = shadowArr[eOut.memAddr];
            if (eOut.memEn && eOut.memWe) shadowArr[eOut.memAddr] = eOut.memDi;
            mdlWait = (bus.dma_req && !eOut.dmaGnt) ? mdlWait + 1 : 0;
        end
    endtask

    task automatic sampleEdge();
        @(negedge clk);
        modelEval();
    endtask

    task automatic advance();
        @(posedge clk);
        modelCommit();
        #1;
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        sramArr[a]   = d;
        shadowArr[a] = d;
    endtask

    vec_t   tbl[$];
    inVec_t idleIn, bothIn, cpuOnlyIn, dmaOnlyIn, cpuRd10, bothRd10, curIn;
    outVec_t zeroOut;

    task automatic addRow(input inVec_t i, input outVec_t o);
        vec_t v;
        v.stim = i;
        v.exp  = o;
        tbl.push_back(v);
    endtask

    initial begin
        idleIn    = mkIn(0, 0, '0, '0, 0, 0, '0, '0);
        bothIn    = mkIn(1, 0, 16'h0001, '0, 1, 0, 16'h0002, '0);
        cpuOnlyIn = mkIn(1, 0, 16'h0001, '0, 0, 0, '0, '0);
        dmaOnlyIn = mkIn(0, 0, '0, '0, 1, 0, 16'h0002, '0);
        cpuRd10   = mkIn(1, 0, 16'h0010, '0, 0, 0, '0, '0);
        bothRd10  = mkIn(1, 0, 16'h0010, '0, 1, 0, 16'h0002, '0);
        zeroOut   = '0;

        mdlWait = 0;
        mdlPend = 1'b0;
        mdlPendDma = 1'b0;
        mdlPendData = '0;
        preload(16'h0010, 32'hDEADBEEF);
        preload(16'h0001, 32'h11111111);
        preload(16'h0002, 32'h22222222);

        // Directed vectors, one per cycle, starting right after reset.
        addRow(idleIn,                                                   mkOut(0,0,0,0,16'h0000,32'h0,        0,32'h0,        0,32'h0,        0));
        addRow(cpuRd10,                                                  mkOut(1,0,1,0,16'h0010,32'h0,        0,32'h0,        0,32'h0,        0));
        addRow(idleIn,                                                   mkOut(0,0,0,0,16'h0000,32'h0,        1,32'hDEADBEEF, 0,32'h0,        0));
        addRow(mkIn(0,0,'0,'0, 1,1,16'h0100,32'h12345678),               mkOut(0,1,1,1,16'h0100,32'h12345678, 0,32'h0,        0,32'h0,        0));
        addRow(mkIn(0,0,'0,'0, 1,0,16'h0100,32'hFFFF0000),               mkOut(0,1,1,0,16'h0100,32'h0,        0,32'h0,        0,32'h0,        0));
        addRow(idleIn,                                                   mkOut(0,0,0,0,16'h0000,32'h0,        0,32'h0,        1,32'h12345678, 0));
        addRow(mkIn(1,0,16'h0001,'0, 0,0,'0,'0),                         mkOut(1,0,1,0,16'h0001,32'h0,        0,32'h0,        0,32'h0,        0));
        addRow(mkIn(0,0,'0,'0, 1,0,16'h0002,'0),                         mkOut(0,1,1,0,16'h0002,32'h0,        1,32'h11111111, 0,32'h0,        0));
        addRow(idleIn,                                                   mkOut(0,0,0,0,16'h0000,32'h0,        0,32'h0,        1,32'h22222222, 0));
        addRow(mkIn(1,1,16'h0030,32'hCAFEF00D, 1,0,16'h0004,32'h5555),   mkOut(1,0,1,1,16'h0030,32'hCAFEF00D, 0,32'h0,        0,32'h0,        0));
        addRow(mkIn(1,0,16'h0030,'0, 0,0,'0,'0),                         mkOut(1,0,1,0,16'h0030,32'h0,        0,32'h0,        0,32'h0,        0));
        addRow(idleIn,                                                   mkOut(0,0,0,0,16'h0000,32'h0,        1,32'hCAFEF00D, 0,32'h0,        0));
        addRow(bothIn,                                                   mkOut(1,0,1,0,16'h0001,32'h0,        0,32'h0,        0,32'h0,        0));
        addRow(bothIn,                                                   mkOut(1,0,1,0,16'h0001,32'h0,        1,32'h11111111, 0,32'h0,        0));
        addRow(bothIn,                                                   mkOut(1,0,1,0,16'h0001,32'h0,        1,32'h11111111, 0,32'h0,        0));
        addRow(bothIn,                                                   mkOut(1,0,1,0,16'h0001,32'h0,        1,32'h11111111, 0,32'h0,        0));
        addRow(bothIn,                                                   mkOut(0,1,1,0,16'h0002,32'h0,        1,32'h11111111, 0,32'h0,        1));
        addRow(bothIn,                                                   mkOut(1,0,1,0,16'h0001,32'h0,        0,32'h0,        1,32'h22222222, 0));
        addRow(idleIn,                                                   mkOut(0,0,0,0,16'h0000,32'h0,        1,32'h11111111, 0,32'h0,        0));

        // Reset: two cycles held, outputs all zero even with requests pending.
        reset = 1'b1;
        applyStimulus(bothIn);
        sampleEdge();
        advance();
        sampleEdge();
        checkOutput("reset", zeroOut);
        advance();
        reset = 1'b0;

        $display("[TB] directed vector table");
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].stim);
            sampleEdge();
            checkOutput($sformatf("vec%0d", i), tbl[i].exp);
            advance();
        end

        $display("[TB] DMA drops request while starved");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bothIn); sampleEdge();
            checkVal($sformatf("dropA.cpu_gnt%0d", i), 64'(bus.cpu_gnt), 64'd1);
            advance();
        end
        applyStimulus(cpuOnlyIn); sampleEdge();
        checkVal("dropA.cpuOnlyGnt", 64'(bus.cpu_gnt), 64'd1);
        checkVal("dropA.stillStarved", 64'(bus.dma_starved), 64'd1);
        advance();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bothIn); sampleEdge();
            checkVal($sformatf("dropA.dma_gnt%0d", i), 64'(bus.dma_gnt), 64'(i == 4));
            checkVal($sformatf("dropA.starved%0d", i), 64'(bus.dma_starved), 64'(i == 4));
            advance();
        end

        $display("[TB] CPU drops request as DMA gains priority");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(bothIn); sampleEdge(); advance();
        end
        applyStimulus(dmaOnlyIn); sampleEdge();
        checkVal("dropB.dma_gnt", 64'(bus.dma_gnt), 64'd1);
        checkVal("dropB.starved", 64'(bus.dma_starved), 64'd1);
        advance();
        applyStimulus(bothIn); sampleEdge();
        checkVal("dropB.cpuBack", 64'(bus.cpu_gnt), 64'd1);
        checkVal("dropB.starvedClr", 64'(bus.dma_starved), 64'd0);
        advance();
        applyStimulus(idleIn); sampleEdge(); advance();

        $display("[TB] reset in the cycle after a CPU read grant");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(bothRd10); sampleEdge();
            checkVal($sformatf("rstC.cpu_gnt%0d", i), 64'(bus.cpu_gnt), 64'd1);
            advance();
        end
        reset = 1'b1;
        applyStimulus(bothRd10); sampleEdge();
        checkOutput("rstC.during", zeroOut);
        advance();
        reset = 1'b0;
        applyStimulus(idleIn); sampleEdge();
        checkOutput("rstC.after", zeroOut);
        advance();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(bothIn); sampleEdge();
            checkVal($sformatf("rstC.dma_gnt%0d", i), 64'(bus.dma_gnt), 64'(i == 4));
            advance();
        end
        applyStimulus(idleIn); sampleEdge(); advance();

        $display("[TB] randomized traffic against reference model");
        curIn = idleIn;
        for (int cyc = 0; cyc < 800; cyc++) begin
            bit cpuHold, dmaHold;
            cpuHold = curIn.cpuReq && !eOut.cpuGnt;
            dmaHold = curIn.dmaReq && !eOut.dmaGnt;
            if (!cpuHold) begin
                curIn.cpuReq   = ($urandom_range(0, 3) != 0);
                curIn.cpuWe    = ($urandom_range(0, 2) == 0);
                curIn.cpuAddr  = ADDR_W'($urandom_range(0, 15));
                curIn.cpuWdata = $urandom;
            end
            if (!dmaHold) begin
                curIn.dmaReq   = ($urandom_range(0, 2) != 0);
                curIn.dmaWe    = ($urandom_range(0, 2) == 0);
                curIn.dmaAddr  = ADDR_W'($urandom_range(0, 15));
                curIn.dmaWdata = $urandom;
            end else if ($urandom_range(0, 9) == 0) begin
                curIn.dmaReq = 1'b0;
            end
            reset = ($urandom_range(0, 99) == 0);
            applyStimulus(curIn);
            sampleEdge();
            checkOutput($sformatf("rand%0d", cyc), eOut);
            advance();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
